// File: rtl/auv_csr_pkg.sv
// Shared types for the Zicsr sequencer: op decode, FSM states, CSR address-space helpers.
package auv_csr_pkg;

  typedef enum logic [1:0] {
    ILL = 2'b00,
    RW  = 2'b01,
    RS  = 2'b10,
    RC  = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } csr_state_e;

  // The two address MSBs set to 2'b11 mark the read-only CSR space.
  function automatic logic csr_is_ro(input logic [1:0] adr_msb);
    return adr_msb == 2'b11;
  endfunction

endpackage

// File: rtl/auv_csr_wdog.sv
// Bus wait watchdog: counts waiting cycles of one request, flags the TIMEOUT-th one.
// expired is combinational so the FSM can trap on the same edge the limit is reached.
module auv_csr_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired = inc && (cnt_q == LAST);

endmodule

// File: rtl/auv_csr_ctrl.sv
// Zicsr sequencer between execute and the CSR bus: decode, optional read, optional write, write-back or trap.
// Stalls the pipeline from the accepting cycle until DONE/ERR; requests are held until ack, err or timeout.
module auv_csr_ctrl
  import auv_csr_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADR_W   = 12,
  parameter int TIMEOUT = 15,
  parameter int RD_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       funct3,
  input  logic [ADR_W-1:0] csr_adr,
  input  logic [XLEN-1:0]  rs1,
  input  logic [RD_W-1:0]  rs1_idx,
  input  logic [RD_W-1:0]  rd_idx,
  output logic             stall,
  output logic             reg_wr,
  output logic [XLEN-1:0]  reg_dat_wr,
  output logic             exc_illegal_inst,
  output logic [ADR_W-1:0] cbus_adr,
  output logic [XLEN-1:0]  cbus_dat_wr,
  input  logic [XLEN-1:0]  cbus_dat_rd,
  output logic             cbus_rd,
  output logic             cbus_wr,
  input  logic             cbus_ack,
  input  logic             cbus_err
);

  csr_state_e       state_q, state_d;
  csr_op_e          op_in, op_q;
  logic             do_rd_in, do_wr_in, ill_in;
  logic             do_rd_q, do_wr_q;
  logic [ADR_W-1:0] adr_q;
  logic [XLEN-1:0]  src_q, old_q, wdat;
  logic [RD_W-1:0]  rd_q;
  logic             wd_clr, wd_inc, wd_expired;

  // Suppression rules: CSRRW with rd=x0 skips the read, CSRRS/C with rs1=x0/uimm=0 skip the write.
  always_comb begin
    op_in    = csr_op_e'(funct3[1:0]);
    do_rd_in = 1'b1;
    do_wr_in = 1'b1;
    if (op_in == RW) begin
      do_rd_in = (rd_idx != '0);
    end else begin
      do_wr_in = (rs1_idx != '0);
    end
    ill_in = (op_in == ILL) || (do_wr_in && csr_is_ro(csr_adr[ADR_W-1 -: 2]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= ILL;
      adr_q   <= '0;
      src_q   <= '0;
      rd_q    <= '0;
      do_rd_q <= 1'b0;
      do_wr_q <= 1'b0;
      old_q   <= '0;
    end else if ((state_q == IDLE) && en) begin
      op_q    <= op_in;
      adr_q   <= csr_adr;
      src_q   <= funct3[2] ? XLEN'(rs1_idx) : rs1;
      rd_q    <= rd_idx;
      do_rd_q <= do_rd_in;
      do_wr_q <= do_wr_in;
      old_q   <= '0;
    end else if ((state_q == RD) && cbus_ack && !cbus_err) begin
      old_q   <= cbus_dat_rd;
    end
  end

  // old_q is zero when the read was suppressed, so set/clear act on an all-zero base.
  always_comb begin
    wdat = src_q;
    case (op_q)
      RS:      wdat = old_q | src_q;
      RC:      wdat = old_q & ~src_q;
      default: wdat = src_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Error beats a simultaneous ack; a late ack on the final waiting cycle still completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (ill_in) begin
            state_d = ERR;
          end else if (do_rd_in) begin
            state_d = RD;
          end else begin
            state_d = WR;
          end
        end
      end
      RD: begin
        if (cbus_err) begin
          state_d = ERR;
        end else if (cbus_ack) begin
          state_d = do_wr_q ? WR : DONE;
        end else if (wd_expired) begin
          state_d = ERR;
        end
      end
      WR: begin
        if (cbus_err) begin
          state_d = ERR;
        end else if (cbus_ack) begin
          state_d = DONE;
        end else if (wd_expired) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall            = 1'b0;
    reg_wr           = 1'b0;
    reg_dat_wr       = '0;
    exc_illegal_inst = 1'b0;
    cbus_rd          = 1'b0;
    cbus_wr          = 1'b0;
    cbus_dat_wr      = '0;
    case (state_q)
      IDLE: stall = en;
      RD: begin
        stall   = 1'b1;
        cbus_rd = 1'b1;
      end
      WR: begin
        stall       = 1'b1;
        cbus_wr     = 1'b1;
        cbus_dat_wr = wdat;
      end
      DONE: begin
        reg_wr     = do_rd_q && (rd_q != '0);
        reg_dat_wr = old_q;
      end
      ERR:     exc_illegal_inst = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign cbus_adr = adr_q;

  assign wd_clr = (state_d != state_q);
  assign wd_inc = (state_q == RD) || (state_q == WR);

  auv_csr_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

endmodule

// File: tb/tb_auv_csr_ctrl.sv
// Bench for auv_csr_ctrl: directed vector table, reset corner sequences, and random ops vs a transaction model.
module tb_auv_csr_ctrl;

  localparam int XLEN    = 32;
  localparam int ADR_W   = 12;
  localparam int TIMEOUT = 4;
  localparam int RD_W    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       funct3;
  logic [ADR_W-1:0] csr_adr;
  logic [XLEN-1:0]  rs1;
  logic [RD_W-1:0]  rs1_idx;
  logic [RD_W-1:0]  rd_idx;
  logic             stall;
  logic             reg_wr;
  logic [XLEN-1:0]  reg_dat_wr;
  logic             exc_illegal_inst;
  logic [ADR_W-1:0] cbus_adr;
  logic [XLEN-1:0]  cbus_dat_wr;
  logic [XLEN-1:0]  cbus_dat_rd;
  logic             cbus_rd;
  logic             cbus_wr;
  logic             cbus_ack;
  logic             cbus_err;

  always #5 clk = ~clk;

  auv_csr_ctrl #(
    .XLEN    (XLEN),
    .ADR_W   (ADR_W),
    .TIMEOUT (TIMEOUT),
    .RD_W    (RD_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .funct3           (funct3),
    .csr_adr          (csr_adr),
    .rs1              (rs1),
    .rs1_idx          (rs1_idx),
    .rd_idx           (rd_idx),
    .stall            (stall),
    .reg_wr           (reg_wr),
    .reg_dat_wr       (reg_dat_wr),
    .exc_illegal_inst (exc_illegal_inst),
    .cbus_adr         (cbus_adr),
    .cbus_dat_wr      (cbus_dat_wr),
    .cbus_dat_rd      (cbus_dat_rd),
    .cbus_rd          (cbus_rd),
    .cbus_wr          (cbus_wr),
    .cbus_ack         (cbus_ack),
    .cbus_err         (cbus_err)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] adr;
    logic [31:0] rs1;
    logic [4:0]  idx;
    logic [4:0]  rd;
    logic [31:0] rd_val;
    int          rd_wait;
    int          wr_wait;
    bit          err_rd;
    bit          err_wr;
    bit          err_ack;
  } op_t;

  typedef struct {
    int          n_rd;
    int          n_wr;
    logic [31:0] wdat;
    int          n_regwr;
    logic [31:0] regdat;
    int          n_exc;
    int          end_cyc;
    bit          stall0;
    bit          proto;
    bit          hung;
  } res_t;

  typedef struct {
    op_t  op;
    res_t exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic op_t mk_op(input logic [2:0] f3, input logic [11:0] adr, input logic [31:0] r1,
                                input logic [4:0] idx, input logic [4:0] rd, input logic [31:0] rv,
                                input int rw, input int ww, input bit er, input bit ew, input bit ea);
    op_t o;
    o.f3 = f3; o.adr = adr; o.rs1 = r1; o.idx = idx; o.rd = rd; o.rd_val = rv;
    o.rd_wait = rw; o.wr_wait = ww; o.err_rd = er; o.err_wr = ew; o.err_ack = ea;
    return o;
  endfunction

  function automatic res_t mk_res(input int nrd, input int nwr, input logic [31:0] wd, input int nrw,
                                  input logic [31:0] rdat, input int nexc, input int endc);
    res_t r;
    r.n_rd = nrd; r.n_wr = nwr; r.wdat = wd; r.n_regwr = nrw; r.regdat = rdat;
    r.n_exc = nexc; r.end_cyc = endc; r.stall0 = 1'b1; r.proto = 1'b0; r.hung = 1'b0;
    return r;
  endfunction

  // Transaction-level reference: what the bus and register file should see for one instruction.
  function automatic res_t model(input op_t o);
    res_t        e;
    logic [1:0]  op;
    logic [31:0] src;
    logic [31:0] old;
    bit          do_rd, do_wr, trap;
    e = mk_res(0, 0, 32'h0, 0, 32'h0, 0, 0);
    op = o.f3[1:0];
    src = o.f3[2] ? {27'h0, o.idx} : o.rs1;
    do_rd = (op == 2'b01) ? (o.rd != 5'd0) : 1'b1;
    do_wr = (op == 2'b01) ? 1'b1 : (o.idx != 5'd0);
    trap = 1'b0;
    old = 32'h0;
    if (op == 2'b00 || (do_wr && o.adr[11:10] == 2'b11)) begin
      e.n_exc = 1;
      e.end_cyc = 1;
      return e;
    end
    if (do_rd) begin
      if (o.rd_wait >= TIMEOUT) begin
        e.n_rd = TIMEOUT; trap = 1'b1;
      end else begin
        e.n_rd = o.rd_wait + 1;
        if (o.err_rd) trap = 1'b1;
        else old = o.rd_val;
      end
    end
    if (do_wr && !trap) begin
      e.wdat = (op == 2'b01) ? src : (op == 2'b10) ? (old | src) : (old & ~src);
      if (o.wr_wait >= TIMEOUT) begin
        e.n_wr = TIMEOUT; trap = 1'b1;
      end else begin
        e.n_wr = o.wr_wait + 1;
        if (o.err_wr) trap = 1'b1;
      end
    end
    e.end_cyc = e.n_rd + e.n_wr + 1;
    e.n_exc = trap ? 1 : 0;
    e.n_regwr = (!trap && do_rd && o.rd != 5'd0) ? 1 : 0;
    e.regdat = old;
    return e;
  endfunction

  // Issue one instruction and act as the CSR bus target until stall drops (bounded).
  task automatic do_op(input op_t o, output res_t g);
    int krd, kwr;
    g = mk_res(0, 0, 32'h0, 0, 32'h0, 0, 0);
    g.stall0 = 1'b0;
    g.hung = 1'b1;
    krd = 0;
    kwr = 0;
    @(posedge clk); #1;
    en = 1'b1; funct3 = o.f3; csr_adr = o.adr; rs1 = o.rs1; rs1_idx = o.idx; rd_idx = o.rd;
    cbus_ack = 1'b0; cbus_err = 1'b0;
    #1;
    g.stall0 = stall;
    if (reg_wr || exc_illegal_inst || cbus_rd || cbus_wr) g.proto = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      en = 1'b0; funct3 = 3'($urandom); csr_adr = 12'($urandom); rs1 = $urandom;
      rs1_idx = 5'($urandom); rd_idx = 5'($urandom);
      cbus_ack = 1'b0; cbus_err = 1'b0; cbus_dat_rd = $urandom;
      if (cbus_rd && cbus_wr) g.proto = 1'b1;
      if ((cbus_rd || cbus_wr) && (cbus_adr !== o.adr)) g.proto = 1'b1;
      if (cbus_rd) begin
        krd++; g.n_rd++;
        if (krd > o.rd_wait) begin
          if (o.err_rd) begin cbus_err = 1'b1; cbus_ack = o.err_ack; end
          else begin cbus_ack = 1'b1; cbus_dat_rd = o.rd_val; end
        end
      end
      if (cbus_wr) begin
        kwr++; g.n_wr++;
        if (kwr == 1) g.wdat = cbus_dat_wr;
        else if (cbus_dat_wr !== g.wdat) g.proto = 1'b1;
        if (kwr > o.wr_wait) begin
          if (o.err_wr) begin cbus_err = 1'b1; cbus_ack = o.err_ack; end
          else cbus_ack = 1'b1;
        end
      end
      #1;
      if (reg_wr) begin g.n_regwr++; g.regdat = reg_dat_wr; end
      if (exc_illegal_inst) g.n_exc++;
      if (!stall) begin
        g.end_cyc = cyc;
        g.hung = 1'b0;
        break;
      end
    end
    cbus_ack = 1'b0;
    cbus_err = 1'b0;
  endtask

  task automatic compare(input string tag, input res_t g, input res_t e);
    chk({tag, ".hung"}, 32'(g.hung), 32'(e.hung));
    chk({tag, ".stall_en"}, 32'(g.stall0), 32'(e.stall0));
    chk({tag, ".n_rd"}, g.n_rd, e.n_rd);
    chk({tag, ".n_wr"}, g.n_wr, e.n_wr);
    if (e.n_wr > 0) chk({tag, ".wdat"}, g.wdat, e.wdat);
    chk({tag, ".n_regwr"}, g.n_regwr, e.n_regwr);
    if (e.n_regwr > 0) chk({tag, ".regdat"}, g.regdat, e.regdat);
    chk({tag, ".n_exc"}, g.n_exc, e.n_exc);
    chk({tag, ".latency"}, g.end_cyc, e.end_cyc);
    chk({tag, ".proto"}, 32'(g.proto), 32'(e.proto));
  endtask

  function automatic logic [31:0] outs_vec();
    return {24'h0, stall, reg_wr, exc_illegal_inst, cbus_rd, cbus_wr,
            |reg_dat_wr, |cbus_dat_wr, |cbus_adr};
  endfunction

  vec_t vecs[$];
  op_t  o;
  res_t g;

  initial begin
    rst = 1'b1; en = 1'b0; funct3 = 3'h0; csr_adr = '0; rs1 = '0; rs1_idx = '0; rd_idx = '0;
    cbus_dat_rd = '0; cbus_ack = 1'b0; cbus_err = 1'b0;

    // f3: [2]=imm, [1:0] 01 RW / 10 RS / 11 RC / 00 illegal; expectations worked out by hand
    vecs.push_back('{mk_op(3'b010, 12'h300, 32'hF0, 5'd1, 5'd5, 32'h0F, 0, 0, 0, 0, 0),
                     mk_res(1, 1, 32'hFF, 1, 32'h0F, 0, 3)});
    vecs.push_back('{mk_op(3'b111, 12'h340, 32'hDEAD, 5'd0, 5'd3, 32'h1234, 0, 0, 0, 0, 0),
                     mk_res(1, 0, 32'h0, 1, 32'h1234, 0, 2)});
    vecs.push_back('{mk_op(3'b001, 12'h305, 32'hCAFE, 5'd7, 5'd0, 32'h9999, 0, 0, 0, 0, 0),
                     mk_res(0, 1, 32'hCAFE, 0, 32'h0, 0, 2)});
    vecs.push_back('{mk_op(3'b001, 12'hC00, 32'h1, 5'd1, 5'd1, 32'h0, 0, 0, 0, 0, 0),
                     mk_res(0, 0, 32'h0, 0, 32'h0, 1, 1)});
    vecs.push_back('{mk_op(3'b011, 12'h300, 32'h0F, 5'd2, 5'd4, 32'hFF, 0, 0, 0, 1, 0),
                     mk_res(1, 1, 32'hF0, 0, 32'h0, 1, 3)});
    vecs.push_back('{mk_op(3'b100, 12'h300, 32'h5, 5'd1, 5'd1, 32'h0, 0, 0, 0, 0, 0),
                     mk_res(0, 0, 32'h0, 0, 32'h0, 1, 1)});
    vecs.push_back('{mk_op(3'b110, 12'hC00, 32'h0, 5'd0, 5'd2, 32'h55, 0, 0, 0, 0, 0),
                     mk_res(1, 0, 32'h0, 1, 32'h55, 0, 2)});
    vecs.push_back('{mk_op(3'b110, 12'hC01, 32'h0, 5'd5, 5'd2, 32'h55, 0, 0, 0, 0, 0),
                     mk_res(0, 0, 32'h0, 0, 32'h0, 1, 1)});
    vecs.push_back('{mk_op(3'b111, 12'h300, 32'h0, 5'h1F, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0),
                     mk_res(1, 1, 32'hFFFF_FFE0, 0, 32'h0, 0, 3)});
    vecs.push_back('{mk_op(3'b001, 12'h301, 32'h11, 5'd1, 5'd1, 32'h22, 2, 1, 0, 0, 0),
                     mk_res(3, 2, 32'h11, 1, 32'h22, 0, 6)});
    vecs.push_back('{mk_op(3'b010, 12'h300, 32'h1, 5'd1, 5'd1, 32'h0, 9, 0, 0, 0, 0),
                     mk_res(4, 0, 32'h0, 0, 32'h0, 1, 5)});
    vecs.push_back('{mk_op(3'b001, 12'h302, 32'hAB, 5'd3, 5'd0, 32'h0, 0, 9, 0, 0, 0),
                     mk_res(0, 4, 32'hAB, 0, 32'h0, 1, 5)});
    vecs.push_back('{mk_op(3'b010, 12'h300, 32'h1, 5'd1, 5'd6, 32'h77, 0, 0, 1, 0, 1),
                     mk_res(1, 0, 32'h0, 0, 32'h0, 1, 2)});
    vecs.push_back('{mk_op(3'b110, 12'h7C0, 32'h0, 5'h1A, 5'd9, 32'h100, 3, 0, 0, 0, 0),
                     mk_res(4, 1, 32'h11A, 1, 32'h100, 0, 6)});

    #12;
    chk("reset.outs", outs_vec(), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].op, g);
      compare($sformatf("vec%0d", i), g, vecs[i].exp);
    end

    // Reset while a write is outstanding: outputs clear at once, next op runs cleanly.
    @(posedge clk); #1;
    en = 1'b1; funct3 = 3'b010; csr_adr = 12'h300; rs1 = 32'hF0; rs1_idx = 5'd1; rd_idx = 5'd5;
    @(posedge clk); #1;
    en = 1'b0; cbus_ack = 1'b1; cbus_dat_rd = 32'h0F;
    @(posedge clk); #1;
    cbus_ack = 1'b0;
    chk("rst_mid.in_wr", 32'(cbus_wr), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid.outs", outs_vec(), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid.idle", outs_vec(), 32'h0);
    do_op(vecs[0].op, g);
    compare("after_rst", g, vecs[0].exp);

    for (int n = 0; n < 200; n++) begin
      o.f3 = 3'($urandom);
      case ($urandom_range(0, 2))
        0:       o.adr = 12'h300 | 12'($urandom_range(0, 63));
        1:       o.adr = {2'b11, 10'($urandom)};
        default: o.adr = 12'($urandom);
      endcase
      o.rs1 = $urandom;
      o.idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      o.rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      o.rd_val = $urandom;
      o.rd_wait = $urandom_range(0, 5);
      o.wr_wait = $urandom_range(0, 5);
      o.err_rd = ($urandom_range(0, 7) == 0);
      o.err_wr = ($urandom_range(0, 7) == 0);
      o.err_ack = 1'($urandom_range(0, 1));
      do_op(o, g);
      compare($sformatf("rnd%0d", n), g, model(o));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
